// File: rtl/alu_secuenciador.sv
// Command FIFO + issue/capture sequencer wrapped around a combinational ALU.
// Optional macro ALU_OPCHECK_EN: opcodes above 4'h9 are trapped and reported on res_err.
module alu_secuenciador #(
    parameter int Ancho = 4,
    parameter int PROF  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [Ancho-1:0]       cmd_a,
    input  logic [Ancho-1:0]       cmd_b,
    input  logic [3:0]             cmd_op,
    input  logic                   cmd_flagin,
    output logic [Ancho-1:0]       A,
    output logic [Ancho-1:0]       B,
    output logic [3:0]             ALUControl,
    output logic                   ALUFlagIn,
    input  logic [Ancho-1:0]       ALUResult,
    input  logic                   ALUFlags,
    input  logic                   Z,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [Ancho-1:0]       res_data,
    output logic                   res_flag,
    output logic                   res_cero,
    output logic [3:0]             res_op,
    output logic                   res_err,
    output logic [$clog2(PROF):0]  cuenta
);
    localparam int PW = $clog2(PROF);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [Ancho-1:0] a;
        logic [Ancho-1:0] b;
        logic [3:0]       op;
        logic             flagin;
    } cmd_t;

    typedef enum logic [1:0] {INACTIVO, EJECUTA, ENTREGA} estado_t;

    estado_t          r_estado, w_siguiente;
    cmd_t             r_mem [PROF];
    logic [PW-1:0]    r_wr, r_rd;
    logic [CW-1:0]    r_cuenta;
    cmd_t             w_cab;
    logic             w_push, w_pop, w_no_vacio, w_captura, w_entrega, w_ilegal;

    logic [Ancho-1:0] r_a, r_b, r_res_data;
    logic [3:0]       r_ctrl, r_op, r_res_op;
    logic             r_fin, r_res_valid, r_res_flag, r_res_cero;

    assign cmd_ready  = (r_cuenta < CW'(PROF));
    assign w_push     = cmd_valid && cmd_ready;
    assign w_no_vacio = (r_cuenta != '0);
    assign w_cab      = r_mem[r_rd];
    assign cuenta     = r_cuenta;

    // ---------------- command FIFO ----------------
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr] <= '{a: cmd_a, b: cmd_b, op: cmd_op, flagin: cmd_flagin};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr     <= '0;
            r_rd     <= '0;
            r_cuenta <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + PW'(1);
            if (w_pop)  r_rd <= r_rd + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cuenta <= r_cuenta + CW'(1);
                2'b01:   r_cuenta <= r_cuenta - CW'(1);
                default: r_cuenta <= r_cuenta;
            endcase
        end
    end

    // ---------------- sequencer FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_estado <= INACTIVO;
        else     r_estado <= w_siguiente;
    end

    always_comb begin
        w_siguiente = r_estado;
        case (r_estado)
            INACTIVO: if (w_no_vacio) w_siguiente = EJECUTA;
            EJECUTA:  w_siguiente = ENTREGA;
            ENTREGA:  if (res_ready) w_siguiente = w_no_vacio ? EJECUTA : INACTIVO;
            default:  w_siguiente = INACTIVO;
        endcase
    end

    always_comb begin
        w_pop     = 1'b0;
        w_captura = 1'b0;
        w_entrega = 1'b0;
        case (r_estado)
            INACTIVO: w_pop = w_no_vacio;
            EJECUTA:  w_captura = 1'b1;
            ENTREGA: begin
                w_entrega = res_ready;
                w_pop     = res_ready && w_no_vacio;
            end
            default: ;
        endcase
    end

    // ---------------- operand registers ----------------
`ifdef ALU_OPCHECK_EN
    logic r_ilegal;
    logic r_res_err;
    assign w_ilegal = (w_cab.op > 4'h9);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_ilegal <= 1'b0;
        else if (w_pop) r_ilegal <= w_ilegal;
    end
`else
    assign w_ilegal = 1'b0;
`endif

    // Trapped opcodes leave the ALU inputs untouched; only the op copy follows the command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_ctrl <= '0;
            r_fin  <= 1'b0;
            r_op   <= '0;
        end else if (w_pop) begin
            r_op <= w_cab.op;
            if (!w_ilegal) begin
                r_a    <= w_cab.a;
                r_b    <= w_cab.b;
                r_ctrl <= w_cab.op;
                r_fin  <= w_cab.flagin;
            end
        end
    end

    // ---------------- result capture ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_flag  <= 1'b0;
            r_res_cero  <= 1'b0;
            r_res_op    <= '0;
        end else if (w_captura) begin
`ifdef ALU_OPCHECK_EN
            r_res_data  <= r_ilegal ? '0 : ALUResult;
            r_res_flag  <= !r_ilegal && ALUFlags;
            r_res_cero  <= !r_ilegal && Z;
`else
            r_res_data  <= ALUResult;
            r_res_flag  <= ALUFlags;
            r_res_cero  <= Z;
`endif
            r_res_op    <= r_op;
            r_res_valid <= 1'b1;
        end else if (w_entrega) begin
            r_res_valid <= 1'b0;
        end
    end

`ifdef ALU_OPCHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_res_err <= 1'b0;
        else if (w_captura) r_res_err <= r_ilegal;
    end
    assign res_err = r_res_err;
`else
    assign res_err = 1'b0;
`endif

    assign A          = r_a;
    assign B          = r_b;
    assign ALUControl = r_ctrl;
    assign ALUFlagIn  = r_fin;
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;
    assign res_flag   = r_res_flag;
    assign res_cero   = r_res_cero;
    assign res_op     = r_res_op;
endmodule

// File: tb/tb_alu_secuenciador.sv
// Bench for alu_secuenciador with an adder ALU stub; honours ALU_OPCHECK_EN when defined.
module tb_alu_secuenciador;
    localparam int Ancho = 4;
    localparam int PROF  = 4;
`ifdef ALU_OPCHECK_EN
    localparam bit OPCHK = 1'b1;
`else
    localparam bit OPCHK = 1'b0;
`endif

    logic             clk = 1'b0, rst = 1'b1;
    logic             cmd_valid = 1'b0, cmd_ready, cmd_flagin = 1'b0;
    logic [Ancho-1:0] cmd_a = '0, cmd_b = '0;
    logic [3:0]       cmd_op = '0;
    logic [Ancho-1:0] A, B, ALUResult, res_data;
    logic [3:0]       ALUControl, res_op;
    logic             ALUFlagIn, ALUFlags, Z;
    logic             res_valid, res_ready = 1'b0, res_flag, res_cero, res_err;
    logic [2:0]       cuenta;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // ALU stub: sum, carry, zero
    logic [Ancho:0] w_suma;
    assign w_suma    = {1'b0, A} + {1'b0, B};
    assign ALUResult = w_suma[Ancho-1:0];
    assign ALUFlags  = w_suma[Ancho];
    assign Z         = (w_suma[Ancho-1:0] == '0);

    alu_secuenciador #(.Ancho(Ancho), .PROF(PROF)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_flagin(cmd_flagin),
        .A(A), .B(B), .ALUControl(ALUControl), .ALUFlagIn(ALUFlagIn),
        .ALUResult(ALUResult), .ALUFlags(ALUFlags), .Z(Z),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_flag(res_flag), .res_cero(res_cero),
        .res_op(res_op), .res_err(res_err), .cuenta(cuenta)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_flagin = op[0];
    endtask

    // ---------------- scoreboard: commands in, beats out in order ----------------
    typedef struct { logic [3:0] a, b, op; } cmd_t;
    cmd_t        q[$];
    logic        hold = 1'b0;
    logic [10:0] prev = '0;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            hold = 1'b0;
        end else begin
            chk("cmd_ready_rule", cmd_ready, cuenta < PROF);
            if (hold) begin
                chk("hold_valid", res_valid, 1);
                chk("hold_beat", {res_data, res_flag, res_cero, res_op, res_err}, prev);
            end
            if (res_valid && res_ready) begin
                if (q.size() == 0) chk("unexpected_beat", q.size(), 1);
                else begin
                    cmd_t c;
                    int   s;
                    bit   il;
                    c  = q.pop_front();
                    s  = int'(c.a) + int'(c.b);
                    il = OPCHK && (c.op > 9);
                    chk("res_data", res_data, il ? 0 : s % 16);
                    chk("res_flag", res_flag, il ? 0 : (s >= 16));
                    chk("res_cero", res_cero, il ? 0 : (s % 16 == 0));
                    chk("res_op",   res_op,   c.op);
                    chk("res_err",  res_err,  il);
                end
            end
            if (cmd_valid && cmd_ready) q.push_back('{a: cmd_a, b: cmd_b, op: cmd_op});
            hold = res_valid && !res_ready;
            prev = {res_data, res_flag, res_cero, res_op, res_err};
        end
    end

    // ---------------- directed vectors ----------------
    int acc, n;
    int t_hs [8];
    int c_hs [8];
    int d_hs [8];
    int o_hs [8];

    initial begin
        // reset values
        tick; tick;
        chk("rst_A", A, 0);             chk("rst_B", B, 0);
        chk("rst_ctrl", ALUControl, 0); chk("rst_fin", ALUFlagIn, 0);
        chk("rst_valid", res_valid, 0); chk("rst_cuenta", cuenta, 0);
        chk("rst_ready", cmd_ready, 1); chk("rst_err", res_err, 0);
        rst = 1'b0;
        tick;

        // single command latency: accepted at edge 0
        put(6, 2, 0); cmd_flagin = 1'b0;
        tick;                                   // edge 0
        cmd_valid = 1'b0;
        chk("single_cuenta_e0", cuenta, 1);
        tick;                                   // edge 1
        chk("single_A_e1", A, 6); chk("single_B_e1", B, 2);
        chk("single_valid_e1", res_valid, 0);
        tick;                                   // edge 2
        chk("single_valid_e2", res_valid, 1); chk("single_data", res_data, 8);
        chk("single_flag", res_flag, 0);      chk("single_cero", res_cero, 0);
        chk("single_op", res_op, 0);
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        chk("single_done", res_valid, 0);

        // capacity with consumer stalled
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            put(4'hF, 4'h1, acc[3:0]);
            if (cmd_ready) acc++;
            tick;
        end
        cmd_valid = 1'b0;
        chk("cap_accepted", acc, 5);
        chk("cap_cuenta", cuenta, 4);
        chk("cap_ready", cmd_ready, 0);
        chk("cap_valid", res_valid, 1);

        // drain: 5 beats, 2 cycles apart, cuenta 4->0
        res_ready = 1'b1;
        n = 0;
        for (int t = 0; t < 16; t++) begin
            if (res_valid && n < 8) begin
                t_hs[n] = t; o_hs[n] = res_op; d_hs[n] = {res_data, res_flag, res_cero};
                tick;
                c_hs[n] = cuenta;
                n++;
            end else tick;
        end
        res_ready = 1'b0;
        chk("drain_beats", n, 5);
        for (int k = 0; k < 5; k++) begin
            chk("drain_op", o_hs[k], k);
            chk("drain_beat", d_hs[k], 6'b0000_11);
            chk("drain_cuenta", c_hs[k], (k < 3) ? 3 - k : 0);
            if (k > 0) chk("drain_gap", t_hs[k] - t_hs[k-1], 2);
        end

        // simultaneous push and pop at cuenta=2
        put(1, 2, 1); tick;
        put(3, 4, 2); tick;
        put(5, 6, 3); tick;
        cmd_valid = 1'b0; tick;
        chk("pp_cuenta_before", cuenta, 2);
        chk("pp_head", res_data, 3);
        put(7, 8, 4); res_ready = 1'b1;
        tick;
        cmd_valid = 1'b0;
        chk("pp_cuenta_after", cuenta, 2);
        n = 0;
        for (int t = 0; t < 16; t++) begin
            if (res_valid && n < 8) begin d_hs[n] = res_data; n++; end
            tick;
        end
        res_ready = 1'b0;
        chk("pp_beats", n, 3);
        chk("pp_order0", d_hs[0], 7);
        chk("pp_order1", d_hs[1], 11);
        chk("pp_order2", d_hs[2], 15);

        // out-of-range opcode after last legal command (7,8,op 4)
        put(6, 2, 4'hA); cmd_flagin = 1'b0;
        tick;
        cmd_valid = 1'b0;
        tick;
`ifdef ALU_OPCHECK_EN
        chk("ill_A_kept", A, 7); chk("ill_B_kept", B, 8);
        chk("ill_ctrl_kept", ALUControl, 4);
`else
        chk("ill_A", A, 6); chk("ill_B", B, 2);
        chk("ill_ctrl", ALUControl, 4'hA);
`endif
        tick;
        chk("ill_valid", res_valid, 1);
        chk("ill_op", res_op, 4'hA);
`ifdef ALU_OPCHECK_EN
        chk("ill_err", res_err, 1); chk("ill_data", res_data, 0);
`else
        chk("ill_err", res_err, 0); chk("ill_data", res_data, 8);
`endif
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;

        // reset mid-operation with results pending
        put(1, 1, 0); tick;
        put(2, 2, 0); tick;
        put(3, 3, 0); tick;
        cmd_valid = 1'b0; tick;
        chk("mid_pending", res_valid, 1);
        rst = 1'b1;
        #1;
        chk("mid_valid", res_valid, 0);  chk("mid_data", res_data, 0);
        chk("mid_flag", res_flag, 0);    chk("mid_cero", res_cero, 0);
        chk("mid_op", res_op, 0);        chk("mid_err", res_err, 0);
        chk("mid_A", A, 0);              chk("mid_B", B, 0);
        chk("mid_ctrl", ALUControl, 0);  chk("mid_fin", ALUFlagIn, 0);
        chk("mid_cuenta", cuenta, 0);    chk("mid_ready", cmd_ready, 1);
        tick; tick;
        rst = 1'b0;
        res_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            tick;
            chk("post_rst_valid", res_valid, 0);
            chk("post_rst_cuenta", cuenta, 0);
        end
        res_ready = 1'b0;
        tick;

        chk("scoreboard_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
